// File: rtl/id_ctrl_pkg.sv
// Shared decode constants, control-word layout and start-kind enum for the ID-stage controller.
package id_ctrl_pkg;

  localparam int CTRL_W = 24;

  // Field LSB offsets, MSB-first from bit 23; bits 1:0 are reserved and always zero.
  localparam int OFF_EXT_OP    = 22;
  localparam int OFF_REG_WRITE = 21;
  localparam int OFF_REG_DST   = 19;
  localparam int OFF_ALU_SRC   = 17;
  localparam int OFF_BRANCH    = 16;
  localparam int OFF_MEM_WRITE = 15;
  localparam int OFF_REG_SRC   = 12;
  localparam int OFF_JUMP      = 11;
  localparam int OFF_ALU_CTRL  = 7;
  localparam int OFF_MD_OP     = 4;
  localparam int OFF_LO_EN     = 3;
  localparam int OFF_HI_EN     = 2;

  localparam logic [3:0] ALU_EQ   = 4'b0000;
  localparam logic [3:0] ALU_NE   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MADD  = 3'b101;
  localparam logic [2:0] MD_MADDU = 3'b110;
  localparam logic [2:0] MD_MSUB  = 3'b111;

  localparam logic [2:0] RS_ALU = 3'b000;
  localparam logic [2:0] RS_MEM = 3'b001;
  localparam logic [2:0] RS_PC8 = 3'b010;
  localparam logic [2:0] RS_HI  = 3'b011;
  localparam logic [2:0] RS_LO  = 3'b100;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] SRC_REG   = 2'b00;
  localparam logic [1:0] SRC_IMM   = 2'b01;
  localparam logic [1:0] SRC_SHAMT = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  localparam logic [5:0] FN_MADD  = 6'h00;
  localparam logic [5:0] FN_MADDU = 6'h01;
  localparam logic [5:0] FN_MSUB  = 6'h04;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  typedef enum logic [1:0] {
    START_NONE = 2'd0,
    START_MULT = 2'd1,
    START_DIV  = 2'd2
  } md_start_e;

  typedef struct packed {
    logic [1:0] ext_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] alu_src;
    logic       branch;
    logic       mem_write;
    logic [2:0] reg_src;
    logic       jump;
    logic [3:0] alu_ctrl;
    logic [2:0] md_op;
    logic       lo_en;
    logic       hi_en;
    logic [1:0] rsvd;
  } ctrl_t;

  // Shift funct low bits pick the operation for both immediate and variable shifts.
  function automatic logic [3:0] shiftAlu(input logic [1:0] kind);
    case (kind)
      2'b10:   return ALU_SRL;
      2'b11:   return ALU_SRA;
      default: return ALU_SLL;
    endcase
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational MIPS decoder producing the control word, illegal flag and MDU classification.
// ID_MADD_EN enables the SPECIAL2 madd/maddu/msub group; otherwise all of opcode 28 is illegal.
module id_decoder
  import id_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o,
  output logic        mdClass_o,
  output md_start_e   start_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign rt    = instr_i[20:16];

  // The all-zero word is the canonical nop and deliberately decodes to an empty control word.
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    mdClass_o = 1'b0;
    start_o   = START_NONE;
    if (instr_i != 32'd0) begin
      case (op)
        OP_SPECIAL: begin
          case (funct)
            FN_SLL, FN_SRL, FN_SRA: begin
              ctrl_o.reg_write = 1'b1;
              ctrl_o.reg_dst   = RD_RD;
              ctrl_o.alu_src   = SRC_SHAMT;
              ctrl_o.alu_ctrl  = shiftAlu(funct[1:0]);
            end
            FN_SLLV, FN_SRLV, FN_SRAV: begin
              ctrl_o.reg_write = 1'b1;
              ctrl_o.reg_dst   = RD_RD;
              ctrl_o.alu_ctrl  = shiftAlu(funct[1:0]);
            end
            FN_JR: ctrl_o.jump = 1'b1;
            FN_JALR: begin
              ctrl_o.jump      = 1'b1;
              ctrl_o.reg_write = 1'b1;
              ctrl_o.reg_dst   = RD_RD;
              ctrl_o.reg_src   = RS_PC8;
            end
            FN_MFHI, FN_MFLO: begin
              ctrl_o.reg_write = 1'b1;
              ctrl_o.reg_dst   = RD_RD;
              ctrl_o.reg_src   = (funct == FN_MFHI) ? RS_HI : RS_LO;
              mdClass_o        = 1'b1;
            end
            FN_MTHI: begin
              ctrl_o.hi_en = 1'b1;
              mdClass_o    = 1'b1;
            end
            FN_MTLO: begin
              ctrl_o.lo_en = 1'b1;
              mdClass_o    = 1'b1;
            end
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              ctrl_o.lo_en = 1'b1;
              ctrl_o.hi_en = 1'b1;
              mdClass_o    = 1'b1;
              case (funct)
                FN_MULT:  ctrl_o.md_op = MD_MULT;
                FN_MULTU: ctrl_o.md_op = MD_MULTU;
                FN_DIV:   ctrl_o.md_op = MD_DIV;
                default:  ctrl_o.md_op = MD_DIVU;
              endcase
              start_o = funct[1] ? START_DIV : START_MULT;
            end
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: begin
              ctrl_o.reg_write = 1'b1;
              ctrl_o.reg_dst   = RD_RD;
              case (funct)
                FN_ADD, FN_ADDU: ctrl_o.alu_ctrl = ALU_ADD;
                FN_SUB, FN_SUBU: ctrl_o.alu_ctrl = ALU_SUB;
                FN_AND:          ctrl_o.alu_ctrl = ALU_AND;
                FN_OR:           ctrl_o.alu_ctrl = ALU_OR;
                FN_XOR:          ctrl_o.alu_ctrl = ALU_XOR;
                FN_NOR:          ctrl_o.alu_ctrl = ALU_NOR;
                FN_SLT:          ctrl_o.alu_ctrl = ALU_SLT;
                default:         ctrl_o.alu_ctrl = ALU_SLTU;
              endcase
            end
            default: illegal_o = 1'b1;
          endcase
        end
        // Sign-test branches use slt; EX compares rs against zero using opcode/rt from ex_instr.
        OP_REGIMM: begin
          if (rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BGEZAL) begin
            ctrl_o.ext_op   = EXT_SIGN;
            ctrl_o.branch   = 1'b1;
            ctrl_o.alu_ctrl = ALU_SLT;
            if (rt == RT_BGEZAL) begin
              ctrl_o.reg_write = 1'b1;
              ctrl_o.reg_dst   = RD_RA;
              ctrl_o.reg_src   = RS_PC8;
            end
          end else begin
            illegal_o = 1'b1;
          end
        end
        OP_J: ctrl_o.jump = 1'b1;
        OP_JAL: begin
          ctrl_o.jump      = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = RD_RA;
          ctrl_o.reg_src   = RS_PC8;
        end
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
          ctrl_o.ext_op   = EXT_SIGN;
          ctrl_o.branch   = 1'b1;
          ctrl_o.alu_ctrl = (op == OP_BEQ) ? ALU_EQ : (op == OP_BNE) ? ALU_NE : ALU_SLT;
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = RD_RT;
          ctrl_o.alu_src   = SRC_IMM;
          ctrl_o.ext_op    = EXT_SIGN;
          case (op)
            OP_ADDI, OP_ADDIU: ctrl_o.alu_ctrl = ALU_ADD;
            OP_SLTI:           ctrl_o.alu_ctrl = ALU_SLT;
            OP_SLTIU:          ctrl_o.alu_ctrl = ALU_SLTU;
            OP_ANDI: begin
              ctrl_o.alu_ctrl = ALU_AND;
              ctrl_o.ext_op   = EXT_ZERO;
            end
            OP_ORI: begin
              ctrl_o.alu_ctrl = ALU_OR;
              ctrl_o.ext_op   = EXT_ZERO;
            end
            OP_XORI: begin
              ctrl_o.alu_ctrl = ALU_XOR;
              ctrl_o.ext_op   = EXT_ZERO;
            end
            default: begin
              ctrl_o.alu_ctrl = ALU_OR;
              ctrl_o.ext_op   = EXT_LUI;
            end
          endcase
        end
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
          ctrl_o.ext_op    = EXT_SIGN;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = RD_RT;
          ctrl_o.alu_src   = SRC_IMM;
          ctrl_o.reg_src   = RS_MEM;
          ctrl_o.alu_ctrl  = ALU_ADD;
        end
        OP_SB, OP_SH, OP_SW: begin
          ctrl_o.ext_op    = EXT_SIGN;
          ctrl_o.alu_src   = SRC_IMM;
          ctrl_o.mem_write = 1'b1;
          ctrl_o.alu_ctrl  = ALU_ADD;
        end
`ifdef ID_MADD_EN
        OP_SPECIAL2: begin
          if (funct == FN_MADD || funct == FN_MADDU || funct == FN_MSUB) begin
            ctrl_o.md_op = (funct == FN_MADD) ? MD_MADD : (funct == FN_MADDU) ? MD_MADDU : MD_MSUB;
            ctrl_o.lo_en = 1'b1;
            ctrl_o.hi_en = 1'b1;
            mdClass_o    = 1'b1;
            start_o      = START_MULT;
          end else begin
            illegal_o = 1'b1;
          end
        end
`endif
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// Decode-stage controller: ID/EX control register, MDU busy counter and structural stall.
// Define ID_MADD_EN to decode the SPECIAL2 madd/maddu/msub group.
module id_ctrl_stage
  import id_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              stall_in,
  input  logic              flush,
  output logic              id_stall,
  output logic              md_busy,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_instr,
  output logic              ex_valid,
  output logic              ex_illegal
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  ctrl_t            decCtrl;
  logic             decIllegal;
  logic             decMdClass;
  md_start_e        decStart;
  logic             mdStall;
  logic             capture;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CTRL_W-1:0] exCtrl_q;
  logic [31:0]      exInstr_q;
  logic             exValid_q, exIllegal_q;

  id_decoder u_decoder (
    .instr_i   (id_instr),
    .ctrl_o    (decCtrl),
    .illegal_o (decIllegal),
    .mdClass_o (decMdClass),
    .start_o   (decStart)
  );

  assign md_busy  = (cnt_q != '0);
  assign mdStall  = id_valid & decMdClass & md_busy;
  assign id_stall = stall_in | mdStall;
  assign capture  = ~flush & ~id_stall;

  // A start only gets captured when the counter is already idle, so loading never races a decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (capture && id_valid && decStart == START_MULT) begin
      cnt_d = MULT_LOAD;
    end else if (capture && id_valid && decStart == START_DIV) begin
      cnt_d = DIV_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      exCtrl_q    <= '0;
      exInstr_q   <= '0;
      exValid_q   <= 1'b0;
      exIllegal_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (capture) begin
        exCtrl_q    <= decCtrl;
        exInstr_q   <= id_instr;
        exValid_q   <= id_valid;
        exIllegal_q <= decIllegal;
      end else begin
        exCtrl_q    <= '0;
        exInstr_q   <= '0;
        exValid_q   <= 1'b0;
        exIllegal_q <= 1'b0;
      end
    end
  end

  assign ex_ctrl    = exCtrl_q;
  assign ex_instr   = exInstr_q;
  assign ex_valid   = exValid_q;
  assign ex_illegal = exIllegal_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: directed scenarios followed by randomized traffic vs a reference model.
module tb_id_ctrl_stage;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_instr;
  logic        id_valid, stall_in, flush;
  logic        id_stall, md_busy;
  logic [23:0] ex_ctrl;
  logic [31:0] ex_instr;
  logic        ex_valid, ex_illegal;

  int checks = 0;
  int errors = 0;

  logic [23:0] expCtrl;
  logic [31:0] expInstr;
  logic        expValid, expIll;
  int          busyRem;

  always #5 clk = ~clk;

  id_ctrl_stage #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_instr   (id_instr),
    .id_valid   (id_valid),
    .stall_in   (stall_in),
    .flush      (flush),
    .id_stall   (id_stall),
    .md_busy    (md_busy),
    .ex_ctrl    (ex_ctrl),
    .ex_instr   (ex_instr),
    .ex_valid   (ex_valid),
    .ex_illegal (ex_illegal)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Control word assembled field by field, MSB first, two reserved zero bits at the bottom.
  function automatic logic [23:0] cw(input logic [1:0] ext, input logic rw, input logic [1:0] dst,
                                     input logic [1:0] src, input logic br, input logic mw,
                                     input logic [2:0] rsel, input logic j, input logic [3:0] alu,
                                     input logic [2:0] md, input logic lo, input logic hi);
    return {ext, rw, dst, src, br, mw, rsel, j, alu, md, lo, hi, 2'b00};
  endfunction

  task automatic refDecode(input logic [31:0] ins, output logic [23:0] w, output logic ill,
                           output logic mdc, output int busy);
    logic [5:0] op, fn;
    logic [4:0] rt;
    op = ins[31:26]; fn = ins[5:0]; rt = ins[20:16];
    w = '0; ill = 1'b0; mdc = 1'b0; busy = 0;
    if (ins != 32'd0) begin
      case (op)
        6'h00: case (fn)
          6'h00: w = cw(0,1,1,2,0,0,0,0,4'hA,0,0,0);
          6'h02: w = cw(0,1,1,2,0,0,0,0,4'h8,0,0,0);
          6'h03: w = cw(0,1,1,2,0,0,0,0,4'h9,0,0,0);
          6'h04: w = cw(0,1,1,0,0,0,0,0,4'hA,0,0,0);
          6'h06: w = cw(0,1,1,0,0,0,0,0,4'h8,0,0,0);
          6'h07: w = cw(0,1,1,0,0,0,0,0,4'h9,0,0,0);
          6'h08: w = cw(0,0,0,0,0,0,0,1,4'h0,0,0,0);
          6'h09: w = cw(0,1,1,0,0,0,2,1,4'h0,0,0,0);
          6'h10: begin w = cw(0,1,1,0,0,0,3,0,0,0,0,0); mdc = 1; end
          6'h11: begin w = cw(0,0,0,0,0,0,0,0,0,0,0,1); mdc = 1; end
          6'h12: begin w = cw(0,1,1,0,0,0,4,0,0,0,0,0); mdc = 1; end
          6'h13: begin w = cw(0,0,0,0,0,0,0,0,0,0,1,0); mdc = 1; end
          6'h18: begin w = cw(0,0,0,0,0,0,0,0,0,1,1,1); mdc = 1; busy = MC; end
          6'h19: begin w = cw(0,0,0,0,0,0,0,0,0,2,1,1); mdc = 1; busy = MC; end
          6'h1A: begin w = cw(0,0,0,0,0,0,0,0,0,3,1,1); mdc = 1; busy = DC; end
          6'h1B: begin w = cw(0,0,0,0,0,0,0,0,0,4,1,1); mdc = 1; busy = DC; end
          6'h20, 6'h21: w = cw(0,1,1,0,0,0,0,0,4'h2,0,0,0);
          6'h22, 6'h23: w = cw(0,1,1,0,0,0,0,0,4'h3,0,0,0);
          6'h24: w = cw(0,1,1,0,0,0,0,0,4'h4,0,0,0);
          6'h25: w = cw(0,1,1,0,0,0,0,0,4'h5,0,0,0);
          6'h26: w = cw(0,1,1,0,0,0,0,0,4'h6,0,0,0);
          6'h27: w = cw(0,1,1,0,0,0,0,0,4'h7,0,0,0);
          6'h2A: w = cw(0,1,1,0,0,0,0,0,4'hC,0,0,0);
          6'h2B: w = cw(0,1,1,0,0,0,0,0,4'hD,0,0,0);
          default: ill = 1'b1;
        endcase
        6'h01: begin
          if (rt == 5'h00 || rt == 5'h01) w = cw(1,0,0,0,1,0,0,0,4'hC,0,0,0);
          else if (rt == 5'h11) w = cw(1,1,2,0,1,0,2,0,4'hC,0,0,0);
          else ill = 1'b1;
        end
        6'h02: w = cw(0,0,0,0,0,0,0,1,0,0,0,0);
        6'h03: w = cw(0,1,2,0,0,0,2,1,0,0,0,0);
        6'h04: w = cw(1,0,0,0,1,0,0,0,4'h0,0,0,0);
        6'h05: w = cw(1,0,0,0,1,0,0,0,4'h1,0,0,0);
        6'h06, 6'h07: w = cw(1,0,0,0,1,0,0,0,4'hC,0,0,0);
        6'h08, 6'h09: w = cw(1,1,0,1,0,0,0,0,4'h2,0,0,0);
        6'h0A: w = cw(1,1,0,1,0,0,0,0,4'hC,0,0,0);
        6'h0B: w = cw(1,1,0,1,0,0,0,0,4'hD,0,0,0);
        6'h0C: w = cw(0,1,0,1,0,0,0,0,4'h4,0,0,0);
        6'h0D: w = cw(0,1,0,1,0,0,0,0,4'h5,0,0,0);
        6'h0E: w = cw(0,1,0,1,0,0,0,0,4'h6,0,0,0);
        6'h0F: w = cw(2,1,0,1,0,0,0,0,4'h5,0,0,0);
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: w = cw(1,1,0,1,0,0,1,0,4'h2,0,0,0);
        6'h28, 6'h29, 6'h2B: w = cw(1,0,0,1,0,1,0,0,4'h2,0,0,0);
`ifdef ID_MADD_EN
        6'h1C: begin
          if (fn == 6'h00 || fn == 6'h01 || fn == 6'h04) begin
            w = cw(0,0,0,0,0,0,0,0,0,(fn == 6'h00) ? 3'd5 : (fn == 6'h01) ? 3'd6 : 3'd7,1,1);
            mdc = 1; busy = MC;
          end else ill = 1'b1;
        end
`endif
        default: ill = 1'b1;
      endcase
    end
  endtask

  // One cycle: drive at negedge, check the combinational stall, then check ID/EX after the edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic s, input logic f);
    logic [23:0] w;
    logic ill, mdc, expStall;
    int busy;
    @(negedge clk);
    id_instr = ins; id_valid = v; stall_in = s; flush = f;
    refDecode(ins, w, ill, mdc, busy);
    #1;
    expStall = s || (v && mdc && busyRem > 0);
    checkOutput("md_busy", 32'(md_busy), 32'(busyRem > 0));
    checkOutput("id_stall", 32'(id_stall), 32'(expStall));
    @(posedge clk);
    if (f || expStall) begin
      expCtrl = '0; expInstr = '0; expValid = 1'b0; expIll = 1'b0;
      if (busyRem > 0) busyRem--;
    end else begin
      expCtrl = w; expInstr = ins; expValid = v; expIll = ill;
      if (v && busy > 0) busyRem = busy;
      else if (busyRem > 0) busyRem--;
    end
    #1;
    checkOutput("ex_ctrl", 32'(ex_ctrl), 32'(expCtrl));
    checkOutput("ex_instr", ex_instr, expInstr);
    checkOutput("ex_valid", 32'(ex_valid), 32'(expValid));
    checkOutput("ex_illegal", 32'(ex_illegal), 32'(expIll));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ex_ctrl"}, 32'(ex_ctrl), 32'd0);
    checkOutput({tag, "_ex_instr"}, ex_instr, 32'd0);
    checkOutput({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    checkOutput({tag, "_ex_illegal"}, 32'(ex_illegal), 32'd0);
    checkOutput({tag, "_md_busy"}, 32'(md_busy), 32'd0);
  endtask

  logic [31:0] pool[$] = '{
    32'h00000021, 32'h00000023, 32'h00000024, 32'h00000025, 32'h0000002A, 32'h00000000,
    32'h00000007, 32'h00000008, 32'h00000009, 32'h00000010, 32'h00000011, 32'h00000012,
    32'h00000013, 32'h00000018, 32'h00000019, 32'h0000001A, 32'h0000001B, 32'h04000000,
    32'h04010000, 32'h04110000, 32'h08000000, 32'h0C000000, 32'h10000000, 32'h14000000,
    32'h18000000, 32'h1C000000, 32'h20000000, 32'h28000000, 32'h2C000000, 32'h30000000,
    32'h34000000, 32'h38000000, 32'h3C000000, 32'h80000000, 32'h94000000, 32'h8C000000,
    32'hA0000000, 32'hAC000000, 32'h70000000, 32'h70000004
  };

  initial begin
    logic [31:0] ins;
    reset = 1'b1; id_instr = '0; id_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    expCtrl = '0; expInstr = '0; expValid = 1'b0; expIll = 1'b0; busyRem = 0;
    #3;
    checkResetState("reset_init");
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(32'h00221821, 1'b1, 1'b0, 1'b0);
    checkOutput("addu_valid", 32'(ex_valid), 32'd1);
    checkOutput("addu_reg_write", 32'(ex_ctrl[21]), 32'd1);
    checkOutput("addu_reg_dst", 32'(ex_ctrl[20:19]), 32'd1);
    checkOutput("addu_alu_ctrl", 32'(ex_ctrl[10:7]), 32'd2);
    checkOutput("addu_md_op", 32'(ex_ctrl[6:4]), 32'd0);

    applyStimulus(32'h00220018, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MC + 1; i++) applyStimulus(32'h00001812, 1'b1, 1'b0, 1'b0);
    checkOutput("mflo_after_mult", ex_instr, 32'h00001812);
    checkOutput("mflo_reg_src", 32'(ex_ctrl[14:12]), 32'd4);

    applyStimulus(32'h0022001A, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h00000000, 1'b1, 1'b0, 1'b0);
    checkOutput("div_flushed_busy", 32'(md_busy), 32'd0);

    applyStimulus(32'h7C000000, 1'b1, 1'b0, 1'b0);
    checkOutput("undef_illegal", 32'(ex_illegal), 32'd1);
    checkOutput("undef_ctrl", 32'(ex_ctrl), 32'd0);

    applyStimulus(32'h70220000, 1'b1, 1'b0, 1'b0);
`ifdef ID_MADD_EN
    checkOutput("madd_md_op", 32'(ex_ctrl[6:4]), 32'd5);
`else
    checkOutput("madd_illegal", 32'(ex_illegal), 32'd1);
`endif
    for (int i = 0; i < MC + 1; i++) applyStimulus(32'h00000021, 1'b1, 1'b0, 1'b0);

    applyStimulus(32'h20010005, 1'b1, 1'b1, 1'b1);
    checkOutput("stall_flush_bubble", 32'(ex_valid), 32'd0);
    applyStimulus(32'h20010005, 1'b1, 1'b0, 1'b0);
    checkOutput("addi_captured", ex_instr, 32'h20010005);

    applyStimulus(32'h0022001B, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h00221821, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    id_valid = 1'b0;
    #2 reset = 1'b1;
    #1 checkResetState("reset_mid");
    expCtrl = '0; expInstr = '0; expValid = 1'b0; expIll = 1'b0; busyRem = 0;
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) ins = $urandom;
      else ins = pool[$urandom_range(0, pool.size() - 1)] | ($urandom & 32'h03E0F800);
      applyStimulus(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Pipelined decode-stage controller for the five-stage MIPS core. Decodes the instruction held in IF/ID into the team's control word, owns the ID/EX control register, and tracks the multiply/divide unit (MDU) with a parametrised busy counter. Generates the MDU structural stall, inserts bubbles on stall and flush, and flags undefined opcodes. Supersedes the purely combinational decoder.

## Interface
Parameters:
- MULT_CYCLES, 5, MDU busy cycles after mult/multu (and madd family), ≥1
- DIV_CYCLES, 10, MDU busy cycles after div/divu, ≥1

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- id_instr  input  32  instruction in IF/ID
- id_valid  input  1  IF/ID holds a real instruction
- stall_in  input  1  data-hazard stall from the hazard unit
- flush  input  1  kill the instruction in ID (branch/jump redirect)
- id_stall  output  1  combinational; freeze PC and IF/ID
- md_busy  output  1  MDU counter nonzero
- ex_ctrl  output  CTRL_W  registered control word in ID/EX
- ex_instr  output  32  registered instruction in ID/EX
- ex_valid  output  1  ID/EX holds a real instruction
- ex_illegal  output  1  ID/EX instruction had an undefined encoding

## Operation
- Control word fields, MSB first: ext_op[1:0], reg_write, reg_dst[1:0], alu_src[1:0], branch, mem_write, reg_src[2:0], jump, alu_ctrl[3:0], md_op[2:0], lo_en, hi_en; CTRL_W = 24.
- alu_ctrl codes: eq 0000, ne 0001, add 0010, sub 0011, and 0100, or 0101, xor 0110, nor 0111, srl 1000, sra 1001, sll 1010, slt 1100, sltu 1101.
- Decoded set: all R-type ALU/shift ops, jr/jalr, mfhi/mthi/mflo/mtlo, mult/multu/div/divu, REGIMM bltz/bgez/bgezal, j/jal, beq/bne/blez/bgtz, I-type ALU ops, lui, lb/lh/lw/lbu/lhu, sb/sh/sw.
- md_op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 madd, 110 maddu, 111 msub.
- id_instr == 0: nop, control word 0, not illegal.
- Any other encoding outside the set: control word 0, illegal = 1.
- MDU-class instruction: md_op ≠ 0 or mf/mt hi/lo.
- md_stall = id_valid & MDU-class & md_busy.
- id_stall = stall_in | md_stall.
- ID/EX update on each clk edge, in priority order:
  - flush: bubble.
  - id_stall: bubble.
  - otherwise: ex_ctrl/ex_instr/ex_illegal from the decode; ex_valid = id_valid.
- Bubble: ex_ctrl = 0, ex_instr = 0, ex_valid = 0, ex_illegal = 0.
- Busy counter cnt, width CNT_W = $clog2(max(MULT_CYCLES, DIV_CYCLES)+1):
  - Loads MULT_CYCLES or DIV_CYCLES on the edge a valid start enters ID/EX. Starts are mult/multu/madd-family for MULT_CYCLES, div/divu for DIV_CYCLES.
  - Otherwise decrements while nonzero; saturates at 0.
  - A start that is flushed or stalled never loads cnt.
  - A start is only admitted when cnt = 0, so load and decrement never collide.

## Timing
- Reset (async, immediate): ex_ctrl 0, ex_instr 0, ex_valid 0, ex_illegal 0, cnt 0, md_busy 0.
- Decode-to-EX latency: 1 cycle.
- id_stall is combinational, valid in the same cycle as id_instr.
- mult captured at edge T:
  - md_busy is high for cycles T+1 … T+MULT_CYCLES.
  - A dependent mflo stalls those cycles and enters EX at edge T+MULT_CYCLES+1.
- Reset mid-count: the counter clears at once. The MDU's own reset discards the result.
- flush and stall_in in the same cycle: flush wins; the result is a bubble either way.

## Configuration
- ID_MADD_EN defined:
  - Opcode 28 decodes madd (funct 0), maddu (funct 1), msub (funct 4) with lo_en = hi_en = 1, busy MULT_CYCLES.
  - Other SPECIAL2 functs are illegal.
- ID_MADD_EN undefined: all of opcode 28 is illegal; md_op values 101–111 are never produced.

## Structure
- Package id_ctrl_pkg holds:
  - field offsets and CTRL_W;
  - alu_ctrl, md_op, reg_src, reg_dst, ext_op localparams;
  - opcode/funct/rt constants.
- Sub-module id_decoder: purely combinational; id_instr → {ctrl word, illegal, md_class, md_start_kind}.
- The top level holds the ID/EX register, counter and stall logic.

## Test plan
- Reset: assert reset mid-cycle → all outputs 0 immediately; md_busy 0.
- addu 0x00221821, id_valid 1 → next cycle ex_valid 1, reg_write 1, reg_dst 01, alu_ctrl 0010, md_op 000.
- mult 0x00220018 then mflo 0x00001812 back-to-back, MULT_CYCLES=5 → md_busy 5 cycles; id_stall 5 cycles; mflo in EX 6 cycles after mult.
- div 0x0022001A, DIV_CYCLES=10, flush asserted same cycle → ex_valid 0, md_busy stays 0.
- Undefined 0x7C000000 → ex_illegal 1, ex_ctrl 0. madd 0x70220000: with ID_MADD_EN → md_op 101, busy 5; without → ex_illegal 1.
- stall_in=1 and flush=1 with addi in ID → bubble; release both → addi captured next edge.
